fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have derived localparam BIT_CYCLES = CLK_FREQ/BAUD (integer division), clocks per serial bit.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port tx_en  input  1  permission to start new frames.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_rdata  input  8  upstream FIFO head data, valid combinationally while fifo_empty=0.
REQ-009 SHALL have port fifo_pop  output  1  one-cycle pop strobe to upstream FIFO.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL use one clock and an asynchronous, active-low reset; all state SHALL change only on rising clk or on falling rst.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 fifo_pop SHALL be combinational: 1 exactly when state=IDLE, tx_en=1, fifo_empty=0; 0 otherwise.
REQ-015 On the edge sampling fifo_pop=1, SHALL capture fifo_rdata into the shift register, move to START and drive tx=0 (registered).
REQ-016 Each of START, every DATA bit, PARITY and STOP SHALL last exactly BIT_CYCLES clocks, timed by a baud counter reset at each bit boundary.
REQ-017 DATA SHALL send 8 bits LSB first, bit index 0..7, then go to PARITY (macro defined) or STOP.
REQ-018 STOP SHALL drive tx=1 for BIT_CYCLES clocks, then return to IDLE.
REQ-019 SHALL spend exactly one IDLE cycle between frames; with FIFO non-empty and tx_en=1 the next pop occurs in that cycle (frame period = 10*BIT_CYCLES+1 clocks, 11*BIT_CYCLES+1 with parity).
REQ-020 tx_en deassertion mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-021 fifo_pop SHALL never assert while fifo_empty=1; at most one pop per frame.
REQ-022 busy SHALL be 1 in every state except IDLE; tx SHALL be 1 in IDLE.
REQ-023 Baud counter SHALL be wide enough for BIT_CYCLES-1 and wrap to 0 at each bit end.

Reset
REQ-024 On rst=0, SHALL immediately force state=IDLE, tx=1, busy=0, fifo_pop=0, baud counter=0, bit index=0, shift register=0.
REQ-025 Reset mid-frame SHALL abandon the byte without re-popping; after rst=1, first pop occurs on the first edge with tx_en=1 and fifo_empty=0.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: defined -> PARITY state inserted after DATA, transmitting even parity (XOR of the 8 data bits) for BIT_CYCLES clocks; undefined -> no PARITY state, DATA goes directly to STOP, 10-bit frame.

Verification (CLK_FREQ=1000, BAUD=100, BIT_CYCLES=10)
REQ-027 Reset held, fifo_empty=0 -> tx=1, fifo_pop=0, busy=0 throughout.
REQ-028 Single byte 8'hA5, tx_en=1 -> one pop cycle, then tx 0,1,0,1,0,0,1,0,1,1 each 10 clocks (with parity: 0 inserted before stop), busy high 100 (110) clocks.
REQ-029 FIFO holding 8'h00, 8'hFF, 8'h3C back-to-back -> exactly 3 pops spaced 101 (111) clocks, bytes decoded in order.
REQ-030 tx_en dropped at clock 30 of a frame -> frame completes, no further pop while tx_en=0; pop follows one clock after tx_en returns to 1.
REQ-031 rst asserted at clock 45 of frame 8'h81 -> tx=1, busy=0 immediately; after release, next FIFO byte sent, 8'h81 never retransmitted.
REQ-032 fifo_empty=1 continuously, tx_en=1 for 500 clocks -> fifo_pop never asserted, tx stays 1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pops bytes from an upstream FIFO and serializes them as 8N1 (or 8E1 with UART_TX_PARITY_EN)
// Ports: clk (rising edge), rst (async active-low), tx_en (allow new frames), fifo_empty/fifo_rdata (FIFO head),
//        fifo_pop (combinational pop strobe), tx (serial line, idle high), busy (frame in progress).
// Macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;
    logic [2:0]    w_next_bit;
    // Gated by rst so no pop is ever signalled while the block is held in reset.
    assign fifo_pop   = rst & (r_state == IDLE) & tx_en & ~fifo_empty;
    assign w_bit_end  = r_cnt == LAST;
    assign w_next_bit = r_bit + 3'd1;
    assign busy       = r_state != IDLE;
    assign tx         = r_tx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
            r_bit <= '0;
            if (fifo_pop) begin
                r_shift <= fifo_rdata;
                r_state <= START;
                r_tx    <= 1'b0;
            end
        end else if (!w_bit_end) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
            case (r_state)
                START: begin
                    r_state <= DATA;
                    r_tx    <= r_shift[0];
                end
                DATA: begin
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= PARITY;
                        r_tx    <= ^r_shift;
`else
                        r_state <= STOP;
                        r_tx    <= 1'b1;
`endif
                    end else begin
                        r_bit <= w_next_bit;
                        r_tx  <= r_shift[w_next_bit];
                    end
                end
                // Unreachable when parity is disabled.
                PARITY: begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule
